// File: rtl/cbfp_if.sv
// cbfp_if: bundle of the CBFP normaliser's data-path signals.
//
// Signals:
//   valid_in                    lanes valid this cycle
//   din_re_p / din_im_p         p-half real/imag, array_size x din_size signed
//   din_re_n / din_im_n         n-half real/imag, array_size x din_size signed
//   dout_re / dout_im           normalised output lanes, array_size x dout_size signed
//   valid_out                   dout_* and idx_out valid
//   idx_out                     shift applied to the current output row
//   ovf                         one-cycle pulse: an input row was dropped
//   dbg_state                   1 while a bank is being drained (FSM state)
//
// Handshake: valid_in/valid_out are plain qualifiers with no ready signal.
// The source never stalls; a row offered while the write bank is still
// occupied is dropped and ovf pulses on the following cycle. A consumer must
// accept every cycle on which valid_out is high.
//
// Modports: master = data source/sink (bench), slave = cbfp_core.
interface cbfp_if #(
  parameter int cnt_size   = 5,
  parameter int array_size = 16,
  parameter int din_size   = 23,
  parameter int dout_size  = 11
);
  logic                                 valid_in;
  logic [array_size-1:0][din_size-1:0]  din_re_p;
  logic [array_size-1:0][din_size-1:0]  din_im_p;
  logic [array_size-1:0][din_size-1:0]  din_re_n;
  logic [array_size-1:0][din_size-1:0]  din_im_n;
  logic [array_size-1:0][dout_size-1:0] dout_re;
  logic [array_size-1:0][dout_size-1:0] dout_im;
  logic                                 valid_out;
  logic [cnt_size-1:0]                  idx_out;
  logic                                 ovf;
  logic                                 dbg_state;

  modport master (
    output valid_in, din_re_p, din_im_p, din_re_n, din_im_n,
    input  dout_re, dout_im, valid_out, idx_out, ovf, dbg_state
  );

  modport slave (
    input  valid_in, din_re_p, din_im_p, din_re_n, din_im_n,
    output dout_re, dout_im, valid_out, idx_out, ovf, dbg_state
  );
endinterface

// File: rtl/cbfp_core.sv
// cbfp_core: convolutional block-floating-point normaliser.
//
// Collects a block of buffer_depth samples per butterfly half (p and n) over
// buffer_depth/array_size valid cycles into one of two ping-pong banks, finds
// the smallest redundant-sign-bit count of each half, and drains the bank as
// 2*rows output rows (p rows first, then n rows), each lane shifted left by
// its half's scale and cut down to dout_size bits.
//
// Ports:
//   clk   rising-edge clock
//   rstn  synchronous reset, active HIGH despite the name
//   bus   cbfp_if.slave (inputs, outputs, ovf, dbg_state)
//
// Build option: define CBFP_ROUND_EN to round half-up and saturate the output;
// without it the output is a plain truncation toward -inf.
module cbfp_core #(
  parameter int cnt_size     = 5,
  parameter int array_size   = 16,
  parameter int din_size     = 23,
  parameter int dout_size    = 11,
  parameter int buffer_depth = 64
) (
  input logic   clk,
  input logic   rstn,
  cbfp_if.slave bus
);
  localparam int rows   = buffer_depth / array_size;
  localparam int row_w  = $clog2(rows);
  localparam int cnt_w  = row_w + 1;
  localparam int groups = array_size / 4;
  localparam int frac   = din_size - dout_size;
  localparam logic [cnt_size-1:0] cnt_max = cnt_size'(din_size - 1);

  typedef logic [array_size-1:0][din_size-1:0] row_t;
  typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  // Leading bits equal to the MSB, minus one.
  function automatic logic [cnt_size-1:0] sign_cnt(input logic [din_size-1:0] x);
    logic [cnt_size-1:0] c;
    logic                run;
    c   = '0;
    run = 1'b1;
    for (int i = din_size - 2; i >= 0; i--) begin
      if (run && (x[i] == x[din_size-1])) c = c + 1'b1;
      else run = 1'b0;
    end
    return c;
  endfunction

  function automatic logic [cnt_size-1:0] min2(input logic [cnt_size-1:0] a,
                                               input logic [cnt_size-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Shift never overflows because s is at most the sign count of x.
  function automatic logic [dout_size-1:0] norm(input logic [din_size-1:0] x,
                                                input logic [cnt_size-1:0] s);
`ifdef CBFP_ROUND_EN
    logic [din_size-1:0] y;
    logic [din_size:0]   r;
    logic [dout_size:0]  q;
    y = x << s;
    r = {y[din_size-1], y} + (din_size+1)'(1 << (frac - 1));
    q = r[din_size:frac];
    // Only the positive end can overflow after adding the half-LSB.
    if (q[dout_size] != q[dout_size-1])
      return q[dout_size] ? {1'b1, {(dout_size-1){1'b0}}} : {1'b0, {(dout_size-1){1'b1}}};
    return q[dout_size-1:0];
`else
    logic [din_size-1:0] y;
    y = x << s;
    return y[din_size-1:frac];
`endif
  endfunction

  row_t mem_re_p [2][rows];
  row_t mem_im_p [2][rows];
  row_t mem_re_n [2][rows];
  row_t mem_im_n [2][rows];

  state_t              state;
  logic                wr_bank, rd_bank;
  logic [row_w-1:0]    wr_row;
  logic [cnt_w-1:0]    rd_cnt;
  logic [1:0]          full;
  logic [cnt_size-1:0] run_p, run_n;
  logic [cnt_size-1:0] scale_p [2];
  logic [cnt_size-1:0] scale_n [2];

  logic [cnt_size-1:0] gmin_p [groups];
  logic [cnt_size-1:0] gmin_n [groups];
  logic [cnt_size-1:0] cyc_min_p, cyc_min_n, blk_min_p, blk_min_n;

  // Per-cycle minimum: 4-lane groups first, then across groups.
  always_comb begin
    cyc_min_p = cnt_max;
    cyc_min_n = cnt_max;
    for (int g = 0; g < groups; g++) begin
      gmin_p[g] = cnt_max;
      gmin_n[g] = cnt_max;
      for (int l = 0; l < 4; l++) begin
        gmin_p[g] = min2(gmin_p[g], min2(sign_cnt(bus.din_re_p[g*4+l]),
                                         sign_cnt(bus.din_im_p[g*4+l])));
        gmin_n[g] = min2(gmin_n[g], min2(sign_cnt(bus.din_re_n[g*4+l]),
                                         sign_cnt(bus.din_im_n[g*4+l])));
      end
      cyc_min_p = min2(cyc_min_p, gmin_p[g]);
      cyc_min_n = min2(cyc_min_n, gmin_n[g]);
    end
  end

  // Row 0 starts a fresh running minimum.
  assign blk_min_p = (wr_row == '0) ? cyc_min_p : min2(run_p, cyc_min_p);
  assign blk_min_n = (wr_row == '0) ? cyc_min_n : min2(run_n, cyc_min_n);

  logic             drain_last, bank_free, accept, start, emit;
  logic [cnt_w-1:0] sel;

  assign drain_last = (state == S_DRAIN) && (rd_cnt == '1);
  // A bank on its final drain cycle may already take row 0 of the next block.
  assign bank_free  = !full[wr_bank] || (drain_last && (rd_bank == wr_bank));
  assign accept     = bus.valid_in && bank_free;
  assign start      = (state == S_IDLE) && full[rd_bank];
  assign emit       = start || (state == S_DRAIN);
  assign sel        = start ? '0 : rd_cnt;
  assign bus.dbg_state = (state == S_DRAIN);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re_p[wr_bank][wr_row] <= bus.din_re_p;
      mem_im_p[wr_bank][wr_row] <= bus.din_im_p;
      mem_re_n[wr_bank][wr_row] <= bus.din_re_n;
      mem_im_n[wr_bank][wr_row] <= bus.din_im_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state   <= S_IDLE;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      rd_cnt  <= '0;
      full    <= '0;
      run_p   <= '0;
      run_n   <= '0;
    end else begin
      if (start) begin
        state  <= S_DRAIN;
        rd_cnt <= cnt_w'(1);
      end else if (state == S_DRAIN) begin
        if (drain_last) begin
          state         <= S_IDLE;
          rd_cnt        <= '0;
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
      if (accept) begin
        run_p <= blk_min_p;
        run_n <= blk_min_n;
        if (wr_row == row_w'(rows - 1)) begin
          full[wr_bank]    <= 1'b1;
          scale_p[wr_bank] <= blk_min_p;
          scale_n[wr_bank] <= blk_min_n;
          wr_bank          <= ~wr_bank;
          wr_row           <= '0;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
    end
  end

  // Current output row: upper half of the drain count selects the n half.
  logic [cnt_size-1:0] cur_scale;
  row_t                cur_re, cur_im;

  always_comb begin
    if (sel[row_w]) begin
      cur_scale = scale_n[rd_bank];
      cur_re    = mem_re_n[rd_bank][sel[row_w-1:0]];
      cur_im    = mem_im_n[rd_bank][sel[row_w-1:0]];
    end else begin
      cur_scale = scale_p[rd_bank];
      cur_re    = mem_re_p[rd_bank][sel[row_w-1:0]];
      cur_im    = mem_im_p[rd_bank][sel[row_w-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      bus.dout_re   <= '0;
      bus.dout_im   <= '0;
      bus.valid_out <= 1'b0;
      bus.idx_out   <= '0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.valid_out <= emit;
      bus.ovf       <= bus.valid_in && !bank_free;
      if (emit) begin
        bus.idx_out <= cur_scale;
        for (int i = 0; i < array_size; i++) begin
          bus.dout_re[i] <= norm(cur_re[i], cur_scale);
          bus.dout_im[i] <= norm(cur_im[i], cur_scale);
        end
      end else begin
        bus.idx_out <= '0;
        bus.dout_re <= '0;
        bus.dout_im <= '0;
      end
    end
  end
endmodule

// File: tb/tb_cbfp_core.sv
// tb_cbfp_core: randomized self-checking bench for cbfp_core.
// The reference model schedules whole blocks: each completed block's drain
// starts at max(completion+1, previous drain end+1) and lasts 8 cycles, and a
// bank accepts new rows again from its last drain cycle on. Expected rows come
// from integer arithmetic on the stored samples.
module tb_cbfp_core;
  localparam int AS = 16;
  localparam int DW = 23;
  localparam int OW = 11;
  localparam int CW = 5;
  localparam int ROW_W = CW + 2*AS*OW;

  logic clk = 1'b0;
  logic rstn = 1'b1;

  cbfp_if #(.cnt_size(CW), .array_size(AS), .din_size(DW), .dout_size(OW)) bus();

  cbfp_core #(.cnt_size(CW), .array_size(AS), .din_size(DW), .dout_size(OW),
              .buffer_depth(64)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int in_re_p[AS], in_im_p[AS], in_re_n[AS], in_im_n[AS];
  int m_re_p[4][AS], m_im_p[4][AS], m_re_n[4][AS], m_im_n[4][AS];
  logic [ROW_W-1:0] exp_q[$];
  int exp_t_q[$];
  int ovf_t_q[$];
  int full_until[2];
  int m_wbank, m_row, last_end, cyc;
  int n_tests = 0;
  int n_fail = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Redundant sign bits = (din_size-1) - smallest n with -2^n <= v < 2^n.
  function automatic int sign_count(input int v);
    int n = 0;
    while (!(v >= -(1 << n) && v < (1 << n))) n++;
    return DW - 1 - n;
  endfunction

  function automatic int expect_out(input int v, input int s);
    longint y, q, d;
    d = longint'(1) << (DW - OW);
    y = longint'(v) * (longint'(1) << s);
`ifdef CBFP_ROUND_EN
    y = y + d / 2;
`endif
    q = y / d;
    if (y < 0 && q * d != y) q = q - 1;
`ifdef CBFP_ROUND_EN
    if (q > 1023) q = 1023;
    if (q < -1024) q = -1024;
`endif
    return int'(q);
  endfunction

  task automatic block_done(input int t);
    int sp, sn, start, r;
    logic [ROW_W-1:0] row;
    sp = DW - 1;
    sn = DW - 1;
    for (int i = 0; i < 4; i++)
      for (int l = 0; l < AS; l++) begin
        if (sign_count(m_re_p[i][l]) < sp) sp = sign_count(m_re_p[i][l]);
        if (sign_count(m_im_p[i][l]) < sp) sp = sign_count(m_im_p[i][l]);
        if (sign_count(m_re_n[i][l]) < sn) sn = sign_count(m_re_n[i][l]);
        if (sign_count(m_im_n[i][l]) < sn) sn = sign_count(m_im_n[i][l]);
      end
    start = (t + 1 > last_end + 1) ? t + 1 : last_end + 1;
    last_end = start + 7;
    full_until[m_wbank] = last_end;
    for (int k = 0; k < 8; k++) begin
      r = k % 4;
      row = '0;
      for (int l = 0; l < AS; l++) begin
        if (k < 4) begin
          row[AS*OW + l*OW +: OW] = OW'(expect_out(m_re_p[r][l], sp));
          row[l*OW +: OW]         = OW'(expect_out(m_im_p[r][l], sp));
        end else begin
          row[AS*OW + l*OW +: OW] = OW'(expect_out(m_re_n[r][l], sn));
          row[l*OW +: OW]         = OW'(expect_out(m_im_n[r][l], sn));
        end
      end
      row[2*AS*OW +: CW] = CW'((k < 4) ? sp : sn);
      exp_q.push_back(row);
      exp_t_q.push_back(start + k);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic r);
    int t;
    logic [ROW_W-1:0] got;
    logic exp_ovf;
    t = cyc + 1;
    if (r) begin
      exp_q.delete();
      exp_t_q.delete();
      ovf_t_q.delete();
      full_until = '{-1, -1};
      m_wbank = 0;
      m_row = 0;
      last_end = -100;
    end else if (v) begin
      if (full_until[m_wbank] <= t) begin
        for (int l = 0; l < AS; l++) begin
          m_re_p[m_row][l] = in_re_p[l];
          m_im_p[m_row][l] = in_im_p[l];
          m_re_n[m_row][l] = in_re_n[l];
          m_im_n[m_row][l] = in_im_n[l];
        end
        if (m_row == 3) begin
          block_done(t);
          m_wbank ^= 1;
          m_row = 0;
        end else begin
          m_row++;
        end
      end else begin
        ovf_t_q.push_back(t);
      end
    end
    rstn = r;
    bus.valid_in = v;
    for (int l = 0; l < AS; l++) begin
      bus.din_re_p[l] = DW'(in_re_p[l]);
      bus.din_im_p[l] = DW'(in_im_p[l]);
      bus.din_re_n[l] = DW'(in_re_n[l]);
      bus.din_im_n[l] = DW'(in_im_n[l]);
    end
    @(posedge clk);
    cyc++;
    #1;
    got = {bus.idx_out, bus.dout_re, bus.dout_im};
    if (exp_t_q.size() > 0 && exp_t_q[0] == cyc) begin
      check("valid_out", bus.valid_out, 1'b1);
      check("row", got, exp_q.pop_front());
      void'(exp_t_q.pop_front());
    end else begin
      check("valid_out", bus.valid_out, 1'b0);
      if (r) check("reset_row", got, '0);
    end
    exp_ovf = (ovf_t_q.size() > 0 && ovf_t_q[0] == cyc);
    check("ovf", bus.ovf, exp_ovf);
    if (exp_ovf) void'(ovf_t_q.pop_front());
  endtask

  task automatic set_all(input int v);
    for (int l = 0; l < AS; l++) begin
      in_re_p[l] = v; in_im_p[l] = v; in_re_n[l] = v; in_im_n[l] = v;
    end
  endtask

  // Random samples with a per-row minimum shift so block scales vary.
  task automatic set_rand();
    int base;
    base = $urandom_range(9, 31);
    for (int l = 0; l < AS; l++) begin
      in_re_p[l] = int'($urandom) >>> $urandom_range(base, 31);
      in_im_p[l] = int'($urandom) >>> $urandom_range(base, 31);
      in_re_n[l] = int'($urandom) >>> $urandom_range(base, 31);
      in_im_n[l] = int'($urandom) >>> $urandom_range(base, 31);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cyc = 0;
    full_until = '{-1, -1};
    m_wbank = 0;
    m_row = 0;
    last_end = -100;
    bus.valid_in = 1'b0;
    set_all(0);

    // Reset with random valid_in.
    for (int i = 0; i < 3; i++) begin
      set_rand();
      step(1'($urandom_range(0, 1)), 1'b1);
    end

    // All-ones block: scale 21, dout 512, drain one cycle after the 4th write.
    set_all(1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    set_all(0);
    step(1'b0, 1'b0);
    check("ones_valid", bus.valid_out, 1'b1);
    check("ones_dout", bus.dout_re[0], 11'd512);
    check("ones_idx", bus.idx_out, 5'd21);
    idle(10);

    // Single full-scale negative sample.
    set_all(0);
    in_re_p[0] = -4194304;
    step(1'b1, 1'b0);
    set_all(0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("fs_dout", bus.dout_re[0], 11'h400);
    check("fs_other", bus.dout_re[1], 11'd0);
    check("fs_idx_p", bus.idx_out, 5'd0);
    idle(4);
    check("fs_idx_n", bus.idx_out, 5'd22);
    idle(6);

    // 4-on/4-off for four blocks: contiguous output, no ovf.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) begin set_rand(); step(1'b1, 1'b0); end
      idle(4);
    end
    idle(12);

    // Gapped block.
    for (int i = 0; i < 7; i++) begin
      set_rand();
      step(1'(i % 2 == 0), 1'b0);
    end
    step(1'b0, 1'b0);
    check("gap_start", bus.valid_out, 1'b1);
    idle(10);

    // 12 consecutive valid cycles: third block overflows.
    for (int i = 0; i < 12; i++) begin set_rand(); step(1'b1, 1'b0); end
    idle(20);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Random soak with occasional resets.
    for (int i = 0; i < 400; i++) begin
      set_rand();
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
    end
    idle(24);

    check("exp_drained", 512'(exp_q.size()), 512'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cbfp_core.md
Name: cbfp_core

Overview:
- Convolutional block-floating-point (CBFP) normaliser between an FFT butterfly stage and the next reduced-width stage.
- Each valid cycle delivers 16 lanes of complex data for two butterfly halves, p and n, at din_size bits.
- The block collects a 64-sample block per half, finds the common minimum redundant-sign-bit count, and left-normalises every sample by it.
- Outputs are truncated to dout_size bits and emitted as 16 lanes/cycle, p half first, then n half, with the scale index alongside.

Parameters:
- cnt_size, 5, width of the sign-bit count / scale index.
- array_size, 16, lanes per cycle.
- din_size, 23, input sample width (signed).
- dout_size, 11, output sample width (signed).
- buffer_depth, 64, samples per half per block; cycles per block = buffer_depth/array_size = 4.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rstn  in  1  reset, synchronous, active-high (asserted = 1) despite the name.
- valid_in  in  1  input lanes valid this cycle.
- din_re_p / din_im_p  in  array_size x din_size signed  p-half real/imag.
- din_re_n / din_im_n  in  array_size x din_size signed  n-half real/imag.
- dout_re / dout_im  out  array_size x dout_size signed  normalised real/imag.
- valid_out  out  1  dout and idx valid.
- idx_out  out  cnt_size  scale (shift) applied to the current output row.
- ovf  out  1  one-cycle pulse when an input block is dropped.

Behaviour:
- Reset (rstn=1 at clk edge): dout_*=0, valid_out=0, idx_out=0, ovf=0, write row counter=0, bank pointers=0, pending flags cleared. Reset mid-block discards partial blocks and any queued output.
- Sign count per sample: number of leading bits equal to the MSB, minus 1; range 0..din_size-1. Value 0 and value -1 give 22.
- Per cycle, for each half, min over the 16 re and 16 im counts, computed as four 4-lane groups then a min across groups.
- Block scale per half: running min across the 4 valid cycles of the block. Re and im share one scale.
- Input: valid_in=1 writes the 16 lanes of all four streams into row wr_row (0..3) of the write bank, then wr_row increments.
  - valid_in=0 holds wr_row; a block may be gapped arbitrarily.
  - On the write of row 3 the bank is marked full with scales scale_p/scale_n, and writing switches to the other bank.
- Ping-pong: two banks, each 4 rows x 16 lanes x 4 streams.
- Output: a full bank is drained in 8 consecutive cycles.
  - Cycles 0-3: p-half rows 0..3 with idx_out=scale_p.
  - Cycles 4-7: n-half rows 0..3 with idx_out=scale_n.
  - valid_out=1 on all 8 cycles.
  - Drain starts the cycle after row 3 is written (registered output: first dout one clk after the last input edge) or, if the other bank is draining, the cycle after that drain ends. No idle gap between back-to-back drains.
- Output arithmetic: y = (x <<< s) within din_size bits (no overflow possible since s ≤ sign count), then dout = y[din_size-1 : din_size-dout_size], truncation toward -inf.
- Overflow: if valid_in=1 while the write bank is still full (not yet drained), the row is discarded, wr_row is unchanged, and ovf pulses. The sustainable rate is a 4-on/4-off valid pattern.
- Simultaneous drain-end and new write into that bank: the write is accepted (the bank frees on the last drain cycle).

Optional Feature:
- Macro CBFP_ROUND_EN.
- Defined: round half-up, adding 1 at bit din_size-dout_size-1 before truncation, then saturate to [-1024, 1023].
- Undefined: pure truncation as above.

Test Plan:
- Reset: hold rstn=1 for 3 cycles with random valid_in -> valid_out=0, all dout=0, ovf=0.
- Single block with every input = 1 -> scale 21 for both halves; after the 4th valid cycle, 8 valid_out cycles with dout=512 (1<<21 then >>12), idx_out=21.
- Block with one sample re_p=-4194304 (full scale), rest 0 -> scale_p=0 and dout of that sample = -1024, others 0; n half all 0 -> scale_n=22, dout 0.
- 4-on/4-off pattern for 4 blocks -> 32 contiguous valid_out cycles, no ovf, p rows precede n rows per block.
- Gapped block (valid 1,0,1,0,1,0,1) -> same output as the contiguous block; drain starts one cycle after the 4th valid edge.
- 12 consecutive valid cycles -> third block's rows dropped with ovf pulses; first two blocks output correctly.
